// File: rtl/vpu_operand_fetch_pkg.sv
// Shared VPU definitions: default datapath widths and the operand-fetch FSM encoding.
package VPU_PKG;

  localparam int SRAM_DATA_WIDTH = 256;
  localparam int DWIDTH_PER_EXEC = 128;
  localparam int SRAM_R_PORT_CNT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vpu_fetch_state_t;

endpackage

// File: rtl/vpu_operand_fifo.sv
// Per-port operand FIFO: registered write, show-ahead read, occupancy count exported
// so the fetch logic can do credit accounting.
module vpu_operand_fifo #(
  parameter int DW    = 256,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wren,
  input  logic [DW-1:0]              wdata,
  input  logic                       rden,
  output logic [DW-1:0]              rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_wr;
  logic             do_rd;

  // A write into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_wr = wren && (!full || rden);
  assign do_rd = rden && !empty;
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (do_rd) begin
        rptr <= rptr + PTR_W'(1);
      end
      if (do_wr && !do_rd) begin
        cnt <= cnt + CNT_W'(1);
      end else if (!do_wr && do_rd) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vpu_operand_fetch.sv
// Vector operand fetch: credit-limited SRAM reads into per-port FIFOs, served to the
// VLANE as EXEC_DW-wide slices with all enabled ports popping in lockstep.
module vpu_operand_fetch
  import VPU_PKG::*;
#(
  parameter int PORT_CNT   = SRAM_R_PORT_CNT,
  parameter int SRAM_DW    = SRAM_DATA_WIDTH,
  parameter int EXEC_DW    = DWIDTH_PER_EXEC,
  parameter int AW         = 10,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [PORT_CNT-1:0]           port_en_i,
  input  logic [PORT_CNT*AW-1:0]        raddr_i,
  input  logic [LEN_W-1:0]              len_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          operand_valid_o,
  input  logic                          operand_rden_i,
  output logic [PORT_CNT*EXEC_DW-1:0]   operand_rdata_o,
  output logic                          operand_last_o,
  output logic [PORT_CNT-1:0]           sram_req_o,
  output logic [PORT_CNT*AW-1:0]        sram_addr_o,
  input  logic [PORT_CNT-1:0]           sram_rvalid_i,
  input  logic [PORT_CNT*SRAM_DW-1:0]   sram_rdata_i
);

  localparam int SLICE_CNT = SRAM_DW / EXEC_DW;
  localparam int SLC_W     = (SLICE_CNT > 1) ? $clog2(SLICE_CNT) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int POP_W     = LEN_W + SLC_W;

  vpu_fetch_state_t state;
  vpu_fetch_state_t state_nxt;

  logic                          launch;
  logic [PORT_CNT-1:0]           en_q;
  logic [LEN_W-1:0]              len_q;
  logic [SLC_W-1:0]              slc_q;
  logic [POP_W-1:0]              consumed_q;
  logic [POP_W-1:0]              total_slices;
  logic                          pop;
  logic                          word_pop;
  logic                          last_slice;

  logic [PORT_CNT-1:0][AW-1:0]      addr_q;
  logic [PORT_CNT-1:0][LEN_W-1:0]   issued_q;
  logic [PORT_CNT-1:0][LEN_W-1:0]   rcvd_q;
  logic [PORT_CNT-1:0][CNT_W-1:0]   outst_q;
  logic [PORT_CNT-1:0][CNT_W-1:0]   fifo_cnt;
  logic [PORT_CNT-1:0][CNT_W-1:0]   credit;
  logic [PORT_CNT-1:0][SRAM_DW-1:0] head;
  logic [PORT_CNT-1:0]              fifo_empty;
  logic [PORT_CNT-1:0]              fifo_full;
  logic [PORT_CNT-1:0]              fifo_rd;
  logic [PORT_CNT-1:0]              push;
  logic [PORT_CNT-1:0]              req;
  logic [PORT_CNT-1:0]              port_ready;

  assign launch       = (state == IDLE) && start_i;
  assign total_slices = POP_W'(len_q) * POP_W'(SLICE_CNT);

  // Disabled ports count as ready so they never hold up the lockstep pop.
  assign port_ready      = ~fifo_empty | ~en_q;
  assign operand_valid_o = (state == RUN) && (&port_ready) && (|en_q);
  assign pop             = operand_valid_o && operand_rden_i;
  assign word_pop        = pop && (slc_q == SLC_W'(SLICE_CNT - 1));
  assign last_slice      = (consumed_q == total_slices - POP_W'(1));
  assign operand_last_o  = operand_valid_o && last_slice;

  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign sram_req_o  = req;
  assign sram_addr_o = addr_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = ((len_i != '0) && (|port_en_i)) ? RUN : DONE;
        end
      end
      RUN: begin
        if (pop && last_slice) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      en_q       <= '0;
      len_q      <= '0;
      slc_q      <= '0;
      consumed_q <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        en_q       <= port_en_i;
        len_q      <= len_i;
        slc_q      <= '0;
        consumed_q <= '0;
      end else if (pop) begin
        slc_q      <= word_pop ? '0 : slc_q + SLC_W'(1);
        consumed_q <= consumed_q + POP_W'(1);
      end
    end
  end

  for (genvar p = 0; p < PORT_CNT; p++) begin : g_port
    logic [SLICE_CNT-1:0][EXEC_DW-1:0] head_slices;

    // Credit covers both words already buffered and reads still in flight.
    assign credit[p]  = CNT_W'(FIFO_DEPTH) - fifo_cnt[p] - outst_q[p];
    assign req[p]     = (state == RUN) && en_q[p] && (issued_q[p] < len_q) && (credit[p] != '0);
    assign fifo_rd[p] = word_pop && en_q[p];
    assign push[p]    = (state == RUN) && en_q[p] && sram_rvalid_i[p] && (rcvd_q[p] < len_q)
                        && (!fifo_full[p] || fifo_rd[p]);

    assign head_slices = head[p];
    assign operand_rdata_o[p*EXEC_DW +: EXEC_DW] =
      (en_q[p] && !fifo_empty[p]) ? head_slices[slc_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        addr_q[p]   <= '0;
        issued_q[p] <= '0;
        rcvd_q[p]   <= '0;
        outst_q[p]  <= '0;
      end else if (launch) begin
        addr_q[p]   <= raddr_i[p*AW +: AW];
        issued_q[p] <= '0;
        rcvd_q[p]   <= '0;
        outst_q[p]  <= '0;
      end else begin
        if (req[p]) begin
          addr_q[p]   <= addr_q[p] + AW'(1);
          issued_q[p] <= issued_q[p] + LEN_W'(1);
        end
        if (push[p]) begin
          rcvd_q[p] <= rcvd_q[p] + LEN_W'(1);
        end
        if (req[p] && !push[p]) begin
          outst_q[p] <= outst_q[p] + CNT_W'(1);
        end else if (!req[p] && push[p]) begin
          outst_q[p] <= outst_q[p] - CNT_W'(1);
        end
      end
    end

    vpu_operand_fifo #(
      .DW    (SRAM_DW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wren  (push[p]),
      .wdata (sram_rdata_i[p*SRAM_DW +: SRAM_DW]),
      .rden  (fifo_rd[p]),
      .rdata (head[p]),
      .empty (fifo_empty[p]),
      .full  (fifo_full[p]),
      .cnt   (fifo_cnt[p])
    );
  end

endmodule

// File: tb/tb_vpu_operand_fetch.sv
// Directed bench for vpu_operand_fetch: SRAM latency model per port, scoreboard of
// expected slices filled at start and drained on every accepted pop.
module tb_vpu_operand_fetch;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [2:0]   port_en_i;
  logic [29:0]  raddr_i;
  logic [7:0]   len_i;
  logic         busy_o;
  logic         done_o;
  logic         operand_valid_o;
  logic         operand_rden_i;
  logic [383:0] operand_rdata_o;
  logic         operand_last_o;
  logic [2:0]   sram_req_o;
  logic [29:0]  sram_addr_o;
  logic [2:0]   sram_rvalid_i = '0;
  logic [767:0] sram_rdata_i  = '0;

  vpu_operand_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .port_en_i       (port_en_i),
    .raddr_i         (raddr_i),
    .len_i           (len_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .operand_valid_o (operand_valid_o),
    .operand_rden_i  (operand_rden_i),
    .operand_rdata_o (operand_rdata_o),
    .operand_last_o  (operand_last_o),
    .sram_req_o      (sram_req_o),
    .sram_addr_o     (sram_addr_o),
    .sram_rvalid_i   (sram_rvalid_i),
    .sram_rdata_i    (sram_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [383:0] data;
    logic         last;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         lat[3];
  int         due_q[3][$];
  logic [9:0] adr_q[3][$];
  logic [9:0] adr_log[3][$];
  int         req_cnt[3];
  logic [2:0] req_seen;
  int         pops;
  int         first_pop;
  int         last_pop;

  function automatic logic [255:0] mk_word(input int p, input logic [9:0] a);
    logic [127:0] lo;
    lo = {64'(p), 54'd0, a} ^ 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
    return {~lo, lo};
  endfunction

  task automatic check_output(input string tag, input logic [383:0] obs, input logic [383:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // SRAM model: requests seen at a rising edge return lat[p] cycles later, in order.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < 3; p++) begin
        due_q[p].delete();
        adr_q[p].delete();
      end
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (sram_req_o[p]) begin
          due_q[p].push_back(cyc + lat[p]);
          adr_q[p].push_back(sram_addr_o[p*10 +: 10]);
          adr_log[p].push_back(sram_addr_o[p*10 +: 10]);
          req_cnt[p]++;
          req_seen[p] = 1'b1;
        end
      end
    end
    cyc++;
    #1;
    for (int p = 0; p < 3; p++) begin
      if (due_q[p].size() > 0 && due_q[p][0] <= cyc) begin
        logic [9:0] a;
        void'(due_q[p].pop_front());
        a = adr_q[p].pop_front();
        sram_rvalid_i[p] = 1'b1;
        sram_rdata_i[p*256 +: 256] = mk_word(p, a);
      end else begin
        sram_rvalid_i[p] = 1'b0;
      end
    end
  end

  // Every accepted pop is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && operand_valid_o && operand_rden_i) begin
      if (pops == 0) first_pop = cyc;
      pops++;
      last_pop = cyc;
      check_output("sb_nonempty", 384'(sb.size() > 0), 384'(1));
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check_output("slice_data", operand_rdata_o, e.data);
        check_output("slice_last", 384'(operand_last_o), 384'(e.last));
      end
    end
  end

  task automatic clear_stats();
    pops     = 0;
    req_seen = '0;
    for (int p = 0; p < 3; p++) begin
      req_cnt[p] = 0;
      adr_log[p].delete();
    end
  endtask

  // Returns during cycle 1 (after the edge that leaves IDLE).
  task automatic apply_stimulus(input logic [2:0] en, input logic [9:0] b0, input logic [9:0] b1,
                                input logic [9:0] b2, input logic [7:0] len);
    logic [9:0] base[3];
    base[0] = b0; base[1] = b1; base[2] = b2;
    if (len != 0 && en != 0) begin
      for (int w = 0; w < int'(len); w++) begin
        for (int s = 0; s < 2; s++) begin
          exp_t e;
          e.data = '0;
          for (int p = 0; p < 3; p++) begin
            logic [255:0] wd;
            wd = mk_word(p, base[p] + 10'(w));
            if (en[p]) e.data[p*128 +: 128] = wd[s*128 +: 128];
          end
          e.last = (w == int'(len) - 1) && (s == 1);
          sb.push_back(e);
        end
      end
    end
    @(posedge clk); #1;
    start_i   = 1'b1;
    port_en_i = en;
    raddr_i   = {b2, b1, b0};
    len_i     = len;
    @(posedge clk); #1;
    start_i   = 1'b0;
    port_en_i = ~en;
    raddr_i   = 30'h2AAA_AAAA;
    len_i     = 8'hC3;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (!done_o && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    check_output({tag, "_done_seen"}, 384'(done_o), 384'(1));
    check_output({tag, "_done_after_last"}, 384'(cyc), 384'(last_pop + 1));
    check_output({tag, "_sb_empty"}, 384'(sb.size()), 384'(0));
    @(posedge clk); #1;
    check_output({tag, "_busy_drop"}, 384'({busy_o, done_o}), 384'(0));
  endtask

  initial begin
    rst_n          = 1'b0;
    start_i        = 1'b0;
    port_en_i      = '0;
    raddr_i        = '0;
    len_i          = '0;
    operand_rden_i = 1'b0;
    lat[0] = 1; lat[1] = 1; lat[2] = 1;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_busy",  384'(busy_o), 384'(0));
    check_output("rst_done",  384'(done_o), 384'(0));
    check_output("rst_valid", 384'(operand_valid_o), 384'(0));
    check_output("rst_rdata", operand_rdata_o, 384'(0));
    check_output("rst_req",   384'(sram_req_o), 384'(0));
    rst_n = 1'b1;

    $display("[TB] basic 3-port fetch, len 2");
    operand_rden_i = 1'b1;
    apply_stimulus(3'b111, 10'h010, 10'h020, 10'h030, 8'd2);
    check_output("c1_busy", 384'(busy_o), 384'(1));
    check_output("c1_req",  384'(sram_req_o), 384'(3'b111));
    check_output("c1_addr", 384'(sram_addr_o), 384'({10'h030, 10'h020, 10'h010}));
    wait_done("basic", 40);
    check_output("basic_pops", 384'(pops), 384'(4));

    $display("[TB] ports 0 and 2 only, len 1");
    clear_stats();
    apply_stimulus(3'b101, 10'h040, 10'h050, 10'h060, 8'd1);
    wait_done("p02", 40);
    check_output("p02_no_req1", 384'(req_seen[1]), 384'(0));
    check_output("p02_req_cnt", 384'({8'(req_cnt[0]), 8'(req_cnt[2])}), 384'({8'd1, 8'd1}));

    $display("[TB] credit stall, len 8, latency 3");
    clear_stats();
    lat[0] = 3; lat[1] = 3; lat[2] = 3;
    operand_rden_i = 1'b0;
    apply_stimulus(3'b111, 10'h100, 10'h200, 10'h300, 8'd8);
    repeat (30) @(posedge clk);
    #1;
    check_output("stall_reqs", 384'({8'(req_cnt[0]), 8'(req_cnt[1]), 8'(req_cnt[2])}),
                 384'({8'd4, 8'd4, 8'd4}));
    operand_rden_i = 1'b1;
    wait_done("stall", 100);
    check_output("stall_pops", 384'(pops), 384'(16));
    check_output("stall_no_gap", 384'(last_pop - first_pop), 384'(15));

    $display("[TB] skewed latency on port 1");
    clear_stats();
    lat[0] = 1; lat[1] = 5; lat[2] = 1;
    apply_stimulus(3'b111, 10'h0A0, 10'h0B0, 10'h0C0, 8'd3);
    wait_done("skew", 100);
    check_output("skew_pops", 384'(pops), 384'(6));

    $display("[TB] address wrap");
    clear_stats();
    lat[1] = 1;
    apply_stimulus(3'b001, 10'h3FF, 10'h000, 10'h000, 8'd2);
    wait_done("wrap", 40);
    check_output("wrap_addrs",
                 384'({(adr_log[0].size() > 0) ? adr_log[0][0] : 10'hx,
                       (adr_log[0].size() > 1) ? adr_log[0][1] : 10'hx}),
                 384'({10'h3FF, 10'h000}));

    $display("[TB] reset mid-fetch");
    clear_stats();
    apply_stimulus(3'b111, 10'h011, 10'h022, 10'h033, 8'd4);
    for (int i = 0; i < 50 && pops < 3; i++) begin
      @(posedge clk); #1;
    end
    check_output("mid_pops", 384'(pops >= 3), 384'(1));
    #2 rst_n = 1'b0;
    #1;
    check_output("mid_rst_flags", 384'({busy_o, done_o, operand_valid_o, operand_last_o}), 384'(0));
    check_output("mid_rst_rdata", operand_rdata_o, 384'(0));
    check_output("mid_rst_sram", 384'({sram_req_o, sram_addr_o}), 384'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_stats();
    apply_stimulus(3'b111, 10'h111, 10'h122, 10'h133, 8'd2);
    wait_done("post_rst", 40);
    check_output("post_rst_pops", 384'(pops), 384'(4));

    $display("[TB] zero length");
    clear_stats();
    apply_stimulus(3'b111, 10'h000, 10'h000, 10'h000, 8'd0);
    check_output("zero_done_c1", 384'({busy_o, done_o}), 384'(2'b11));
    @(posedge clk); #1;
    check_output("zero_idle", 384'({busy_o, done_o}), 384'(0));
    check_output("zero_no_req", 384'(req_cnt[0] + req_cnt[1] + req_cnt[2]), 384'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
